// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter.
// Holds the FSM state encoding and the I2C direction encoding.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [7:0] CODEC_ADDR = 8'h34;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_i, wrapping around, returned both one-hot and as a binary index.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        // Offsets 1..NUM_REQ so last_i itself is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                win_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C master command port between NUM_REQ requesters with
// round-robin arbitration, start timeout and per-requester done/err pulses.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int START_TMO = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    // Handshake: a requester raises req[i] with its command and holds it until
    // the cycle it sees done[i]; the command is captured at launch, so the
    // requester's addr/data/dir may change once grant[i] is high.
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_wr_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    input  logic                      i2c_busy,
    output logic                      i2c_start,
    output logic                      i2c_wr_rd,
    output logic [ADDR_W-1:0]         i2c_addr,
    output logic [DATA_W-1:0]         i2c_data,
    output logic [2:0]                dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [15:0] TMO = 16'(START_TMO);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                start_q, start_d;
    logic                wr_rd_q, wr_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  pick_win;
    logic [IDX_W-1:0]    pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (pick_win),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        wr_rd_d = wr_rd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req && !i2c_busy) begin
                    state_d = ST_START;
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
                    start_d = 1'b1;
                    wr_rd_d = req_wr_rd[pick_idx];
                    addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (i2c_busy) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    // Compare the incremented value so DONE lands START_TMO+1
                    // cycles after the start strobe.
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TMO) begin
                        state_d = ST_DONE;
                        done_d  = grant_q;
                        err_d   = grant_q;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (!i2c_busy) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                last_d  = gidx_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            wr_rd_q <= I2C_WR;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            wr_rd_q <= wr_rd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign i2c_start   = start_q;
    assign i2c_wr_rd   = wr_rd_q;
    assign i2c_addr    = addr_q;
    assign i2c_data    = data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with two requesters and START_TMO=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_i2c_cmd_arbiter;

    localparam int S_IDLE    = 0;
    localparam int S_START   = 1;
    localparam int S_WAIT_HI = 2;
    localparam int S_WAIT_LO = 3;
    localparam int S_DONE    = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_addr;
    logic [1:0]  req_wr_rd;
    logic [31:0] req_data;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        i2c_busy;
    logic        i2c_start;
    logic        i2c_wr_rd;
    logic [7:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic [2:0]  dbg_state;

    int pass_cnt = 0;
    int total    = 0;

    i2c_cmd_arbiter #(
        .NUM_REQ   (2),
        .ADDR_W    (8),
        .DATA_W    (16),
        .START_TMO (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_wr_rd   (req_wr_rd),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .i2c_busy    (i2c_busy),
        .i2c_start   (i2c_start),
        .i2c_wr_rd   (i2c_wr_rd),
        .i2c_addr    (i2c_addr),
        .i2c_data    (i2c_data),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Starts from an IDLE cycle with req already driven; one-cycle busy pulse.
    task automatic xfer(input logic [1:0] g, input logic [7:0] a, input logic [15:0] d,
                        input logic w);
        tick();
        check("xfer_grant", 32'(grant), 32'(g));
        check("xfer_start", 32'(i2c_start), 32'd1);
        check("xfer_addr", 32'(i2c_addr), 32'(a));
        check("xfer_data", 32'(i2c_data), 32'(d));
        check("xfer_wr_rd", 32'(i2c_wr_rd), 32'(w));
        tick();
        check("xfer_start_clr", 32'(i2c_start), 32'd0);
        check("xfer_wait_hi", 32'(dbg_state), S_WAIT_HI);
        i2c_busy = 1'b1;
        tick();
        check("xfer_wait_lo", 32'(dbg_state), S_WAIT_LO);
        i2c_busy = 1'b0;
        tick();
        check("xfer_done", 32'(done), 32'(g));
        check("xfer_err", 32'(err), 32'd0);
        check("xfer_grant_hold", 32'(grant), 32'(g));
    endtask

    initial begin
        reset     = 1'b1;
        req       = 2'b00;
        req_addr  = '0;
        req_wr_rd = 2'b00;
        req_data  = '0;
        i2c_busy  = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_start", 32'(i2c_start), 32'd0);
        check("rst_addr", 32'(i2c_addr), 32'd0);
        check("rst_data", 32'(i2c_data), 32'd0);
        check("rst_wr_rd", 32'(i2c_wr_rd), 32'd0);
        check("rst_state", 32'(dbg_state), S_IDLE);
        reset = 1'b0;
        tick();

        // Single request, busy high for 3 cycles
        req_addr  = {8'h50, 8'h34};
        req_data  = {16'hBEEF, 16'h0A00};
        req_wr_rd = 2'b10;
        req       = 2'b01;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_start", 32'(i2c_start), 32'd1);
        check("t1_addr", 32'(i2c_addr), 32'h34);
        check("t1_data", 32'(i2c_data), 32'h0A00);
        check("t1_wr_rd", 32'(i2c_wr_rd), 32'd0);
        tick();
        check("t1_start_clr", 32'(i2c_start), 32'd0);
        i2c_busy = 1'b1;
        tick();
        check("t1_wait_lo", 32'(dbg_state), S_WAIT_LO);
        tick();
        tick();
        i2c_busy = 1'b0;
        check("t1_no_done_yet", 32'(done), 32'd0);
        tick();
        check("t1_done", 32'(done), 32'h1);
        check("t1_err", 32'(err), 32'd0);
        req = 2'b00;
        tick();
        check("t1_done_clr", 32'(done), 32'd0);
        check("t1_grant_clr", 32'(grant), 32'd0);
        check("t1_idle", 32'(dbg_state), S_IDLE);
        check("t1_addr_stable", 32'(i2c_addr), 32'h34);

        // Simultaneous requests after reset: requester 0 first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_addr  = {8'h3A, 8'h34};
        req_data  = {16'h2222, 16'h1111};
        req_wr_rd = 2'b00;
        req       = 2'b11;
        xfer(2'b01, 8'h34, 16'h1111, 1'b0);
        req = 2'b10;
        tick();
        check("t2_idle_gap", 32'(grant), 32'd0);
        xfer(2'b10, 8'h3A, 16'h2222, 1'b0);

        // Continuous requests alternate
        req = 2'b11;
        tick();
        xfer(2'b01, 8'h34, 16'h1111, 1'b0);
        tick();
        xfer(2'b10, 8'h3A, 16'h2222, 1'b0);
        tick();
        xfer(2'b01, 8'h34, 16'h1111, 1'b0);
        tick();
        xfer(2'b10, 8'h3A, 16'h2222, 1'b0);
        req = 2'b00;
        tick();

        // Start timeout: busy never rises
        req_data = {16'h2222, 16'h5A5A};
        req      = 2'b01;
        tick();
        check("t4_start", 32'(i2c_start), 32'd1);
        check("t4_data", 32'(i2c_data), 32'h5A5A);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t4_no_done", 32'(done), 32'd0);
        end
        tick();
        check("t4_done", 32'(done), 32'h1);
        check("t4_err", 32'(err), 32'h1);
        req = 2'b00;
        tick();
        check("t4_idle", 32'(dbg_state), S_IDLE);
        check("t4_err_clr", 32'(err), 32'd0);

        // Busy already high when requesting: hold off
        i2c_busy = 1'b1;
        req      = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_grant", 32'(grant), 32'd0);
            check("t5_no_start", 32'(i2c_start), 32'd0);
        end
        i2c_busy = 1'b0;
        tick();
        check("t5_grant", 32'(grant), 32'h1);
        check("t5_start", 32'(i2c_start), 32'd1);
        tick();
        i2c_busy = 1'b1;
        tick();
        check("t5_wait_lo", 32'(dbg_state), S_WAIT_LO);

        // Asynchronous reset during WAIT_LO
        reset = 1'b1;
        #1;
        check("t6_rst_grant", 32'(grant), 32'd0);
        check("t6_rst_start", 32'(i2c_start), 32'd0);
        check("t6_rst_addr", 32'(i2c_addr), 32'd0);
        check("t6_rst_data", 32'(i2c_data), 32'd0);
        check("t6_rst_state", 32'(dbg_state), S_IDLE);
        #1;
        reset     = 1'b0;
        i2c_busy  = 1'b0;
        req_addr  = {8'h3B, 8'h34};
        req_data  = {16'hC0DE, 16'h5A5A};
        req_wr_rd = 2'b10;
        req       = 2'b10;
        xfer(2'b10, 8'h3B, 16'hC0DE, 1'b1);
        req = 2'b00;
        tick();
        check("t6_final_idle", 32'(dbg_state), S_IDLE);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
